uart_receiver: RTL

//  Serial-to-parallel UART receive path; receiving end of the transmit-side serial line.

---
 rtl/uart_receiver_pkg.sv | 19 +
 rtl/uart_rx_tick_gen.sv | 56 +++++
 rtl/uart_receiver.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared UART receive types and default timing constants.
package uart_receiver_pkg;

    // Default timing shared with the transmit side: 50 MHz / (115200 * 16) ~= 27
    localparam int unsigned DEF_DIVISOR    = 27;
    localparam int unsigned DEF_OVERSAMPLE = 16;
    localparam int unsigned DEF_DATA_BITS  = 8;

    // Receiver frame states
    typedef enum logic [2:0] {
        UART_RX_IDLE   = 3'd0,
        UART_RX_START  = 3'd1,
        UART_RX_DATA   = 3'd2,
        UART_RX_PARITY = 3'd3,
        UART_RX_STOP   = 3'd4,
        UART_RX_BREAK  = 3'd5
    } uart_rx_state_e;

endpackage : uart_receiver_pkg

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: clk prescaler plus modulo-OVERSAMPLE tick counter.
// tick_o is high for one clk per DIVISOR clks; cnt_o holds the number of ticks
// seen since the last clear (before the current tick is counted).
module uart_rx_tick_gen
    import uart_receiver_pkg::*;
#(
    parameter int unsigned DIVISOR    = DEF_DIVISOR,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clr_i,
    output logic                          tick_o,
    output logic [$clog2(OVERSAMPLE)-1:0] cnt_o
);

    localparam int unsigned PW = $clog2(DIVISOR);
    localparam int unsigned TW = $clog2(OVERSAMPLE);

    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next-state: tick is registered one clk early so it lines up with the prescaler wrap
    always_comb begin
        presc_d = presc_q + PW'(1);
        cnt_d   = cnt_q;
        tick_d  = (presc_q == PW'(DIVISOR - 2));
        if (presc_q == PW'(DIVISOR - 1)) begin
            presc_d = '0;
            cnt_d   = (cnt_q == TW'(OVERSAMPLE - 1)) ? '0 : cnt_q + TW'(1);
        end
        if (clr_i) begin
            presc_d = '0;
            cnt_d   = '0;
            tick_d  = 1'b0;
        end
    end

    // Prescaler, tick and tick counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;
    assign cnt_o  = cnt_q;

endmodule : uart_rx_tick_gen

// File: rtl/uart_receiver.sv
// UART receive path: synchronise rx, validate start, sample bit midpoints,
// check parity/stop and present the word on a valid/ready handshake.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned DIVISOR    = DEF_DIVISOR,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun_error
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    logic rx_meta_q, rx_s_q;

    logic          tick;
    logic [TW-1:0] tick_cnt;
    logic          tick_clr_c;

    uart_rx_state_e       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 busy_q, busy_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 ov_q, ov_d;

    logic mid_start_c;
    logic bit_end_c;
    logic accept_c;
    logic parity_bad_c;
    logic deliver_c;

    // Two-flop synchroniser for the asynchronous rx line (idles high)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    uart_rx_tick_gen #(
        .DIVISOR    (DIVISOR),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (tick_clr_c),
        .tick_o (tick),
        .cnt_o  (tick_cnt)
    );

    assign mid_start_c  = tick && (tick_cnt == TW'(OVERSAMPLE / 2 - 1));
    assign bit_end_c    = tick && (tick_cnt == TW'(OVERSAMPLE - 1));
    assign accept_c     = rx_valid_q && rx_ready;
    assign parity_bad_c = PARITY_EN && (par_bit_q != ((^shift_q) ^ PARITY_ODD));

    // Frame FSM, shifter, error flags and output handshake next-state
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_bit_d  = par_bit_q;
        tick_clr_c = 1'b0;
        deliver_c  = 1'b0;
        fe_d       = 1'b0;
        pe_d       = 1'b0;
        ov_d       = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;

        case (state_q)
            UART_RX_IDLE: begin
                if (!rx_s_q) begin
                    tick_clr_c = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = UART_RX_START;
                end
            end
            UART_RX_START: begin
                if (mid_start_c) begin
                    if (rx_s_q) begin
                        state_d = UART_RX_IDLE;
                    end else begin
                        tick_clr_c = 1'b1;
                        state_d    = UART_RX_DATA;
                    end
                end
            end
            UART_RX_DATA: begin
                if (bit_end_c) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = PARITY_EN ? UART_RX_PARITY : UART_RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            UART_RX_PARITY: begin
                if (bit_end_c) begin
                    par_bit_d = rx_s_q;
                    state_d   = UART_RX_STOP;
                end
            end
            UART_RX_STOP: begin
                if (bit_end_c) begin
                    pe_d = parity_bad_c;
                    if (rx_s_q) begin
                        deliver_c = !parity_bad_c;
                        state_d   = UART_RX_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = UART_RX_BREAK;
                    end
                end
            end
            UART_RX_BREAK: begin
                if (rx_s_q) begin
                    state_d = UART_RX_IDLE;
                end
            end
            default: begin
                state_d = UART_RX_IDLE;
            end
        endcase

        // Handshake: accept clears valid; a delivery into an unaccepted word is an overrun
        if (accept_c) begin
            rx_valid_d = 1'b0;
        end
        if (deliver_c) begin
            if (rx_valid_q && !accept_c) begin
                ov_d = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
        end

        busy_d = (state_d != UART_RX_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= UART_RX_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_bit_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_bit_q  <= par_bit_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            ov_q       <= ov_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign busy          = busy_q;
    assign framing_error = fe_q;
    assign parity_error  = pe_q;
    assign overrun_error = ov_q;

endmodule : uart_receiver
